// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply or restoring divide
// on operand magnitudes, with sign correction applied when the last iteration completes.
module execute_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      rd_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, stateNext;
  logic [4:0]      count;
  logic [2:0]      opReg;
  logic [4:0]      rdReg;
  logic [XLEN-1:0] magA, magB;
  logic [XLEN-1:0] accHi, accLo;
  logic            negRes;

  function automatic logic [2*XLEN-1:0] negateWide(input logic [2*XLEN-1:0] v, input logic neg);
    negateWide = neg ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] negateWord(input logic [XLEN-1:0] v, input logic neg);
    negateWord = neg ? -v : v;
  endfunction

  // Operand decode and magnitude conversion for a newly issued operation
  logic signed [XLEN-1:0] aSigned, bSigned;
  logic            signedA, signedB, negA, negB;
  logic            isDivIn, divZero, divOvf, specialCase, negNext;
  logic [XLEN-1:0] inMagA, inMagB, specialResult;

  assign aSigned = op_a_i;
  assign bSigned = op_b_i;

  always_comb begin
    signedA = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    signedB = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    negA    = signedA && aSigned[XLEN-1];
    negB    = signedB && bSigned[XLEN-1];
    inMagA  = negA ? $unsigned(-aSigned) : op_a_i;
    inMagB  = negB ? $unsigned(-bSigned) : op_b_i;
    isDivIn = op_i[2];
    divZero = (op_b_i == '0);
    divOvf  = isDivIn && !op_i[0] && (op_a_i == MinNeg) && (op_b_i == '1);
    specialCase = isDivIn && (divZero || divOvf);
    // Remainder follows the dividend; product and quotient follow the sign difference
    negNext = (isDivIn && op_i[1]) ? negA : (negA ^ negB);
    if (divZero) specialResult = op_i[1] ? op_a_i : '1;
    else         specialResult = op_i[1] ? '0 : MinNeg;
  end

  // One iteration of the shared datapath
  logic [XLEN:0]     mulSum;
  logic [XLEN:0]     divShifted;
  logic              divGeq;
  logic [XLEN-1:0]   nextHi, nextLo, divRaw;
  logic [2*XLEN-1:0] mulProd;
  logic [XLEN-1:0]   finalResult;

  always_comb begin
    mulSum     = {1'b0, accHi} + (accLo[0] ? {1'b0, magA} : '0);
    divShifted = {accHi, accLo[XLEN-1]};
    divGeq     = divShifted >= {1'b0, magB};
    if (opReg[2]) begin
      nextHi = divGeq ? (divShifted[XLEN-1:0] - magB) : divShifted[XLEN-1:0];
      nextLo = {accLo[XLEN-2:0], divGeq};
    end else begin
      nextHi = mulSum[XLEN:1];
      nextLo = {mulSum[0], accLo[XLEN-1:1]};
    end
    mulProd = negateWide({nextHi, nextLo}, negRes);
    divRaw  = opReg[1] ? nextHi : nextLo;
    if (opReg[2])              finalResult = negateWord(divRaw, negRes);
    else if (opReg[1:0] == 2'd0) finalResult = mulProd[XLEN-1:0];
    else                       finalResult = mulProd[2*XLEN-1:XLEN];
  end

  // Sequencing
  logic accept, lastIter;

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    lastIter  = 1'b0;
    case (state)
      IDLE: begin
        if (!flush_i && start_i) begin
          accept    = 1'b1;
          stateNext = specialCase ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush_i) begin
          stateNext = IDLE;
        end else if (&count) begin
          lastIter  = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        if (flush_i) begin
          stateNext = IDLE;
        end else if (start_i) begin
          accept    = 1'b1;
          stateNext = specialCase ? DONE : CALC;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
      rd_o     <= '0;
      count    <= '0;
      opReg    <= '0;
      rdReg    <= '0;
      magA     <= '0;
      magB     <= '0;
      accHi    <= '0;
      accLo    <= '0;
      negRes   <= 1'b0;
    end else begin
      state   <= stateNext;
      busy_o  <= (stateNext == CALC);
      valid_o <= (stateNext == DONE);
      if (accept) begin
        opReg  <= op_i;
        rdReg  <= rd_i;
        magA   <= inMagA;
        magB   <= inMagB;
        negRes <= negNext;
        count  <= '0;
        accHi  <= '0;
        // Divide shifts the dividend out of accLo; multiply shifts the multiplier out
        accLo  <= isDivIn ? inMagA : inMagB;
        if (specialCase) begin
          result_o <= specialResult;
          rd_o     <= rd_i;
        end
      end else if (state == CALC && !flush_i) begin
        accHi <= nextHi;
        accLo <= nextLo;
        count <= count + 5'd1;
        if (lastIter) begin
          result_o <= finalResult;
          rd_o     <= rdReg;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: directed RV32M cases, randomized
// operations against an arithmetic reference model, flush, back-to-back and reset.
module tb_execute_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] op_a_i, op_b_i;
  logic [4:0]  rd_i;
  logic        busy_o, valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int errors = 0;
  int checks = 0;

  execute_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .flush_i(flush_i),
    .op_i(op_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .rd_i(rd_i),
    .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic with the RV32M corner-case rules
  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    longint unsigned ua, uub;
    logic [63:0] p;
    int qs;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ua  = {32'd0, a};
    uub = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * uub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        qs = $signed(a) / $signed(b); return qs;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        qs = $signed(a) % $signed(b); return qs;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one operation and wait (bounded) for its completion pulse
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output int busyCnt);
    op_i = op; op_a_i = a; op_b_i = b; rd_i = rd; start_i = 1'b1;
    step();
    start_i = 1'b0;
    lat = -1; busyCnt = 0; res = 32'hDEAD_BEEF; rdo = 5'd0;
    for (int c = 1; c <= 40; c++) begin
      if (valid_o) begin
        lat = c; res = result_o; rdo = rd_o;
        break;
      end
      if (busy_o) busyCnt++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 0; flush_i = 0; op_i = 0; op_a_i = 0; op_b_i = 0; rd_i = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL reset_result got=%h want=0", result_o); end
    checks++; if (rd_o !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d want=0", rd_o); end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    logic [2:0]  ops [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'h1234, 32'h1234,
                              32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234,
                              32'h8000_0000, 32'h0};
    logic [31:0] res; logic [4:0] rdo; int lat, busyCnt, wantLat;
    for (int i = 0; i < 12; i++) begin
      wantLat = (i >= 8) ? 1 : 33;
      run_op(ops[i], as[i], bs[i], 5'(i + 1), res, rdo, lat, busyCnt);
      checks++; if (res !== exp[i]) begin errors++; $display("FAIL dir%0d_result got=%h want=%h", i, res, exp[i]); end
      checks++; if (rdo !== 5'(i + 1)) begin errors++; $display("FAIL dir%0d_rd got=%0d want=%0d", i, rdo, i + 1); end
      checks++; if (lat != wantLat) begin errors++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, wantLat); end
      checks++; if (busyCnt != wantLat - 1) begin errors++; $display("FAIL dir%0d_busy_cycles got=%0d want=%0d", i, busyCnt, wantLat - 1); end
      step();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL dir%0d_valid_pulse got=%b want=0", i, valid_o); end
      checks++; if (result_o !== exp[i]) begin errors++; $display("FAIL dir%0d_hold got=%h want=%h", i, result_o, exp[i]); end
    end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [31:0] a, b, res; logic [4:0] rd, rdo; int lat, busyCnt, sel;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom; rd = 5'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 300) - 150; b = $urandom_range(1, 20); end
      run_op(op, a, b, rd, res, rdo, lat, busyCnt);
      checks++; if (res !== refModel(op, a, b)) begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, res, refModel(op, a, b)); end
      checks++; if (rdo !== rd) begin errors++; $display("FAIL rnd%0d_rd got=%0d want=%0d", i, rdo, rd); end
      checks++; if (lat != refLatency(op, a, b)) begin errors++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, refLatency(op, a, b)); end
      if ($urandom_range(0, 1) == 1) step();
    end
    step();
  endtask

  task automatic test_flush();
    logic [31:0] res; logic [4:0] rdo; int lat, busyCnt, seen;
    run_op(3'd0, 32'd12, 32'd11, 5'd17, res, rdo, lat, busyCnt);
    checks++; if (res !== 32'd132) begin errors++; $display("FAIL flush_setup got=%h want=%h", res, 32'd132); end
    step();
    op_i = 3'd5; op_a_i = 32'd999; op_b_i = 32'd3; rd_i = 5'd4; start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (10) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b want=0", busy_o); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (valid_o || busy_o) seen++;
      step();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_valid got=%0d active cycles want=0", seen); end
    checks++; if (result_o !== 32'd132) begin errors++; $display("FAIL flush_result got=%h want=%h", result_o, 32'd132); end
    checks++; if (rd_o !== 5'd17) begin errors++; $display("FAIL flush_rd got=%0d want=17", rd_o); end
  endtask

  task automatic test_ignored_start();
    int cyc, seen;
    op_i = 3'd0; op_a_i = 32'h0001_0003; op_b_i = 32'h0000_0205; rd_i = 5'd3; start_i = 1'b1;
    step();
    start_i = 1'b0; cyc = 1;
    repeat (5) begin step(); cyc++; end
    op_i = 3'd5; op_a_i = 32'd5; op_b_i = 32'd0; rd_i = 5'd9; start_i = 1'b1;
    step(); cyc++;
    start_i = 1'b0;
    while (!valid_o && cyc < 40) begin step(); cyc++; end
    checks++; if (cyc != 33) begin errors++; $display("FAIL ignstart_latency got=%0d want=33", cyc); end
    checks++; if (result_o !== refModel(3'd0, 32'h0001_0003, 32'h0000_0205)) begin errors++; $display("FAIL ignstart_result got=%h want=%h", result_o, refModel(3'd0, 32'h0001_0003, 32'h0000_0205)); end
    checks++; if (rd_o !== 5'd3) begin errors++; $display("FAIL ignstart_rd got=%0d want=3", rd_o); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (valid_o) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL ignstart_extra_valid got=%0d want=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; logic [4:0] rdo; int lat, busyCnt;
    run_op(3'd4, 32'hFFFF_FC18, 32'd7, 5'd10, res, rdo, lat, busyCnt);
    checks++; if (res !== refModel(3'd4, 32'hFFFF_FC18, 32'd7)) begin errors++; $display("FAIL b2b_first got=%h want=%h", res, refModel(3'd4, 32'hFFFF_FC18, 32'd7)); end
    run_op(3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 5'd11, res, rdo, lat, busyCnt);
    checks++; if (lat != 33) begin errors++; $display("FAIL b2b_gap got=%0d want=33", lat); end
    checks++; if (res !== refModel(3'd1, 32'h8000_0000, 32'h7FFF_FFFF)) begin errors++; $display("FAIL b2b_second got=%h want=%h", res, refModel(3'd1, 32'h8000_0000, 32'h7FFF_FFFF)); end
    checks++; if (rdo !== 5'd11) begin errors++; $display("FAIL b2b_rd got=%0d want=11", rdo); end
    run_op(3'd7, 32'h55, 32'd0, 5'd12, res, rdo, lat, busyCnt);
    checks++; if (lat != 1) begin errors++; $display("FAIL b2b_special_gap got=%0d want=1", lat); end
    checks++; if (res !== 32'h55) begin errors++; $display("FAIL b2b_special got=%h want=%h", res, 32'h55); end
    step();
  endtask

  task automatic test_reset_mid();
    int seen;
    op_i = 3'd3; op_a_i = 32'hABCD_1234; op_b_i = 32'h1357_9BDF; rd_i = 5'd21; start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (15) step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b want=0", valid_o); end
    checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL rstmid_result got=%h want=0", result_o); end
    checks++; if (rd_o !== 5'd0) begin errors++; $display("FAIL rstmid_rd got=%0d want=0", rd_o); end
    #1 rst_n = 1'b1;
    step();
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (valid_o || busy_o) seen++;
      step();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_after got=%0d active cycles want=0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_unit.md
# execute_muldiv_unit

Iterative multiply/divide unit for RV32M instructions in the execute stage. It sits directly downstream of the decode/execute pipeline register, in parallel with the ALU. It takes operand A (OP1E) and operand B (RegRD2E), runs a 32-iteration shift-add multiply or restoring divide, and returns a tagged 32-bit result. While it works, it stalls the upstream stages through `busy_o`.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; only 32 is supported.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  request a new operation; sampled only in IDLE or DONE.
- `flush_i`  in  1  abort the in-flight operation (branch or jump redirect).
- `op_i`  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op_a_i`  in  32  operand A (rs1).
- `op_b_i`  in  32  operand B (rs2).
- `rd_i`  in  5  destination register tag.
- `busy_o`  out  1  stall request to the fetch, decode and decode/execute register.
- `valid_o`  out  1  one-cycle pulse: `result_o` and `rd_o` are valid.
- `result_o`  out  32  operation result.
- `rd_o`  out  5  destination tag of the completed operation.

## Operation
States and transitions:
- **IDLE**
  - `start_i` = 1: latch `op_i`, `rd_i` and both operands; clear the iteration counter (5 bits).
  - Special divide case: go to DONE.
  - Otherwise: go to CALC.
- **CALC**
  - One iteration per cycle; the counter increments each cycle.
  - After the iteration with counter = 31, go to DONE.
- **DONE**
  - Register the result, pulse `valid_o`, then return to IDLE.
  - If `start_i` = 1 in DONE, the new operation is accepted exactly as in IDLE (back-to-back issue).
- `start_i` in CALC is ignored.

Signed handling:
- Signed operands are converted to magnitude at latch time:
  - A is signed for MULH, MULHSU, DIV and REM.
  - B is signed for MULH, DIV and REM.
- The core datapath is unsigned.
- Final negation:
  - Product is negated iff the operand signs differ.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.

Multiply:
- 64-bit accumulator using shift-add over the B bits, LSB first.
- MUL returns the low 32 bits.
- MULH, MULHSU and MULHU return the high 32 bits of the signed-corrected 64-bit product.

Divide:
- Restoring division with a 33-bit partial remainder, one quotient bit per iteration, MSB first.

Special cases (go to DONE without entering CALC):
- Divisor = 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return operand A.
- DIV/REM with A = 0x80000000 and B = 0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.

Flush:
- `flush_i` = 1 in CALC or DONE forces IDLE on the next edge.
- `valid_o` stays 0 for the aborted operation.
- `result_o` and `rd_o` keep their previous values.
- A flush has priority over `start_i` in the same cycle.

## Timing
Reset values:
- State: IDLE.
- `busy_o` = 0, `valid_o` = 0, `result_o` = 0, `rd_o` = 0; counter and internal operands = 0.

Output behaviour:
- `busy_o` is a registered output. It is 1 exactly while the state is CALC, and 0 in IDLE and DONE, so the pipeline advances in the DONE cycle.
- The decode/execute register must hold its contents while `busy_o` = 1.
- `valid_o` is 1 for exactly one cycle (the DONE cycle). `result_o` and `rd_o` update in that same cycle and hold until the next completion.

Latency:
- Normal operation: `start_i` sampled at edge N; CALC occupies cycles N+1..N+32; `valid_o` is high in cycle N+33.
- Special divide cases: `valid_o` is high in cycle N+1.

Back-to-back issue:
- `start_i` is asserted in a DONE cycle: the next operation enters CALC at the following edge with no idle cycle.

Reset during operation:
- `rst_n` falling in any state immediately clears all outputs and returns to IDLE, independent of `clk`.
- Deassertion is synchronised externally.

## Test plan
- MUL: A = 7, B = 0xFFFFFFFD (−3), start at edge N → `busy_o` high N+1..N+32; `valid_o` high in cycle N+33 only; `result_o` = 0xFFFFFFEB; `rd_o` = latched tag.
- MULHU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU: A = 0xFFFFFFFF, B = 2 → 0xFFFFFFFF.
- DIV: −7 / 2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU with the same operands → 2.
- Divisor zero:
  - DIVU 0x1234 / 0 → `valid_o` in cycle N+1, `result_o` = 0xFFFFFFFF, `busy_o` never high.
  - REM 0x1234 / 0 → 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Flush and ignored start:
  - Assert `flush_i` at CALC cycle 10 → IDLE next edge; no `valid_o`; `result_o` unchanged.
  - Assert `start_i` during CALC → ignored; the original result is unaffected.
- Back-to-back and reset:
  - Second `start_i` in the DONE cycle → second `valid_o` exactly 33 cycles after the first.
  - Assert `rst_n` = 0 mid-CALC → all outputs 0 immediately; no `valid_o` after release.
